// File: rtl/sw_led_ctrl_if.sv
// sw_led_ctrl_if: switch/LED signal bundle; master drives sw/mode, slave drives led/sw_stable/sw_rise
interface sw_led_ctrl_if #(parameter int N_CH = 8);
  logic [0:N_CH-1] sw;
  logic [1:0]      mode;
  logic [0:N_CH-1] led;
  logic [0:N_CH-1] sw_stable;
  logic [0:N_CH-1] sw_rise;
  modport master (output sw, mode, input led, sw_stable, sw_rise);
  modport slave  (input sw, mode, output led, sw_stable, sw_rise);
endinterface

// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: synchronise and debounce N_CH switches, drive N_CH LEDs in one of four display modes
// Ports: clk_100_in (board clock), rst_in (sync active-high reset), io.sw/io.mode in,
// io.led/io.sw_stable/io.sw_rise out. Define SW_LED_DIM_EN for 25% duty PWM dimming of led.
module sw_led_ctrl #(
  parameter int N_CH            = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_DIV       = 25000000
) (
  input logic          clk_100_in,
  input logic          rst_in,
  sw_led_ctrl_if.slave io
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [0:N_CH-1] sync_q [SYNC_STAGES];
  logic [0:N_CH-1] sync_d [SYNC_STAGES];
  logic [DW-1:0]   cnt_q [N_CH];
  logic [DW-1:0]   cnt_d [N_CH];
  logic [0:N_CH-1] stable_q, stable_d, rise_q, rise_d, tog_q, tog_d, led_q, led_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d, wrap;
  always_comb begin
    sync_d[0] = io.sw;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    stable_d = stable_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[SYNC_STAGES-1][i] != stable_q[i]) begin
        if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync_q[SYNC_STAGES-1][i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // rise is taken from the acceptance itself so the pulse coincides with the first stable-high cycle
    rise_d  = stable_d & ~stable_q;
    tog_d   = tog_q ^ rise_q;
    wrap    = blink_q == BW'(BLINK_DIV - 1);
    blink_d = wrap ? '0 : blink_q + 1'b1;
    phase_d = phase_q ^ wrap;
    led_d   = io.mode == 2'd0 ? stable_q :
              io.mode == 2'd1 ? tog_q :
              io.mode == 2'd2 ? stable_q & {N_CH{phase_q}} : '0;
  end
  always_ff @(posedge clk_100_in) begin
    if (rst_in) begin
      sync_q   <= '{default: '0};
      cnt_q    <= '{default: '0};
      stable_q <= '0;
      rise_q   <= '0;
      tog_q    <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      led_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      tog_q    <= tog_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end
  assign io.sw_stable = stable_q;
  assign io.sw_rise   = rise_q;
`ifdef SW_LED_DIM_EN
  logic [1:0]      pwm_q, pwm_d;
  logic [0:N_CH-1] dim_q, dim_d;
  always_comb begin
    pwm_d = pwm_q + 1'b1;
    dim_d = led_q & {N_CH{pwm_q == 2'd0}};
  end
  always_ff @(posedge clk_100_in) begin
    if (rst_in) begin
      pwm_q <= '0;
      dim_q <= '0;
    end else begin
      pwm_q <= pwm_d;
      dim_q <= dim_d;
    end
  end
  assign io.led = dim_q;
`else
  assign io.led = led_q;
`endif
endmodule

// File: tb/tb_sw_led_ctrl.sv
// tb_sw_led_ctrl: directed self-checking bench for sw_led_ctrl (default build, no dimming)
module tb_sw_led_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  sw_led_ctrl_if #(.N_CH(8)) io ();
  sw_led_ctrl #(
    .N_CH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8)
  ) dut (
    .clk_100_in(clk),
    .rst_in(rst),
    .io(io)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    io.sw = '0;
    io.mode = 2'd0;
    do_reset();
    checks++;
    if ({io.led, io.sw_stable, io.sw_rise} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: led=%h stable=%h rise=%h expected all 00", io.led, io.sw_stable, io.sw_rise);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({io.led, io.sw_stable, io.sw_rise} !== 24'h0) begin
        errors++;
        $display("FAIL idle_c%0d: led=%h stable=%h rise=%h expected all 00", c, io.led, io.sw_stable, io.sw_rise);
      end
    end
  endtask
  task automatic test_clean_step();
    io.sw[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (io.sw_stable[0] !== (e >= 5) || io.sw_rise[0] !== (e == 5) || io.led[0] !== (e >= 6)) begin
        errors++;
        $display("FAIL clean_step_e%0d: stable0=%b rise0=%b led0=%b expected %b %b %b",
                 e, io.sw_stable[0], io.sw_rise[0], io.led[0], e >= 5, e == 5, e >= 6);
      end
    end
    io.sw[0] = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (io.sw_stable !== 8'h00 || io.led !== 8'h00) begin
      errors++;
      $display("FAIL clean_release: stable=%h led=%h expected 00 00", io.sw_stable, io.led);
    end
  endtask
  task automatic test_bounce();
    logic [0:6] pat = 7'b1110111;
    for (int c = 0; c < 17; c++) begin
      io.sw[3] = c < 7 ? pat[c] : 1'b0;
      tick();
      checks++;
      if (io.sw_stable[3] !== 1'b0 || io.sw_rise[3] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_c%0d: stable3=%b rise3=%b expected 0 0", c, io.sw_stable[3], io.sw_rise[3]);
      end
    end
  endtask
  task automatic test_toggle();
    logic [0:7] exp_led [2] = '{8'h84, 8'h80};
    io.mode = 2'd1;
    for (int p = 0; p < 2; p++) begin
      io.sw[5] = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      checks++;
      if (io.led !== exp_led[p] || io.sw_stable[5] !== 1'b1) begin
        errors++;
        $display("FAIL toggle_press%0d: led=%h stable5=%b expected %h 1", p, io.led, io.sw_stable[5], exp_led[p]);
      end
      io.sw[5] = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      checks++;
      if (io.led !== exp_led[p] || io.sw_stable[5] !== 1'b0) begin
        errors++;
        $display("FAIL toggle_release%0d: led=%h stable5=%b expected %h 0", p, io.led, io.sw_stable[5], exp_led[p]);
      end
    end
  endtask
  task automatic test_blink();
    logic [7:0] exp;
    io.mode = 2'd2;
    io.sw = '0;
    do_reset();
    io.sw = 8'hFF;
    for (int e = 0; e < 42; e++) begin
      tick();
      exp = ((e >= 8 && e <= 15) || (e >= 24 && e <= 31) || e >= 40) ? 8'hFF : 8'h00;
      checks++;
      if (io.led !== exp) begin
        errors++;
        $display("FAIL blink_e%0d: led=%h expected %h", e, io.led, exp);
      end
    end
    io.mode = 2'd3;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (io.led !== 8'h00) begin
        errors++;
        $display("FAIL mode_off_c%0d: led=%h expected 00", c, io.led);
      end
    end
  endtask
  task automatic test_back_to_back();
    io.mode = 2'd3;
    io.sw = '0;
    do_reset();
    io.sw = 8'h60;
    for (int e = 0; e < 5; e++) tick();
    io.mode = 2'd0;
    tick();
    checks++;
    if (io.sw_stable !== 8'h60 || io.sw_rise !== 8'h60 || io.led !== 8'h00) begin
      errors++;
      $display("FAIL simul_accept: stable=%h rise=%h led=%h expected 60 60 00", io.sw_stable, io.sw_rise, io.led);
    end
    tick();
    checks++;
    if (io.led !== 8'h60 || io.sw_rise !== 8'h00) begin
      errors++;
      $display("FAIL simul_led: led=%h rise=%h expected 60 00", io.led, io.sw_rise);
    end
  endtask
  task automatic test_reset_mid();
    io.mode = 2'd0;
    io.sw = '0;
    do_reset();
    io.sw[7] = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (io.sw_stable !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_clear: stable=%h expected 00", io.sw_stable);
    end
    for (int f = 0; f < 8; f++) begin
      tick();
      checks++;
      if (io.sw_stable[7] !== (f >= 5) || io.sw_rise[7] !== (f == 5)) begin
        errors++;
        $display("FAIL reset_mid_f%0d: stable7=%b rise7=%b expected %b %b",
                 f, io.sw_stable[7], io.sw_rise[7], f >= 5, f == 5);
      end
    end
  endtask
  initial begin
    io.sw = '0;
    io.mode = 2'd0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_toggle();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_led_ctrl.md
Name: sw_led_ctrl

Overview:
Parametrised successor to the board-level switch-to-LED register path. It synchronises and debounces N_CH slide-switch inputs, then drives N_CH LEDs in one of four runtime-selectable display modes. It sits directly behind the FPGA pins on the 100 MHz board clock. It also exports the clean switch state and rising-edge pulses for use by downstream logic.

Parameters:
N_CH, 8, number of switch/LED channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive cycles a new level must persist before it is accepted (>=1)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=1)

Ports:
clk_100_in  input  1  board clock, 100 MHz; all logic on rising edge
rst_in  input  1  synchronous, active-high reset
sw  input  [0:N_CH-1]  raw asynchronous switch pins
mode  input  2  display mode select; synchronous to clk_100_in
led  output  [0:N_CH-1]  registered LED drive
sw_stable  output  [0:N_CH-1]  debounced switch state
sw_rise  output  [0:N_CH-1]  one-cycle pulse on each 0->1 transition of sw_stable

Behaviour:
- Interface: one clock, clk_100_in; reset rst_in is synchronous and active-high.
- Reset values: all sync flops, debounce counters, sw_stable, sw_rise, toggle latches, blink counter, blink phase, and led are 0.
- Sync: each channel passes through a SYNC_STAGES-flop chain. The last stage is s[i].
- Debounce, per channel:
  - The counter width is clog2(DEBOUNCE_CYCLES)+1.
  - If s[i]==sw_stable[i], the counter is cleared to 0.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 and s[i] still differs, sw_stable[i]<=s[i] and the counter is cleared.
  - Any bounce back to the old level before acceptance clears the counter, so no partial credit carries over.
- Latency: sw changes before edge 0 and then holds. sw_stable updates at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. led updates in mode 00 at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- sw_rise[i] is registered and is high for exactly the one cycle after sw_stable[i] goes 0->1. There is no pulse on 1->0 transitions.
- Toggle latch tog[i]: inverted on each sw_rise[i]. It updates in every mode and is not cleared on a mode change.
- Blink:
  - A free-running counter runs 0..BLINK_DIV-1 and wraps.
  - The blink phase toggles on the cycle the counter wraps.
  - The counter is not affected by mode.
- led register, next value by mode:
  - 00: sw_stable
  - 01: tog
  - 10: sw_stable & {N_CH{phase}}
  - 11: all 0
- Mode changes are reflected on led one cycle after mode is sampled.
- Simultaneous events:
  - If a channel's acceptance and a mode change happen in the same cycle, both take effect; led reflects the new mode with the new sw_stable on the following cycle.
  - Channels are fully independent; several channels may accept in the same cycle.
- Reset mid-debounce: partial counts are discarded. After rst_in deasserts, a held-high switch needs the full SYNC_STAGES+DEBOUNCE_CYCLES again before it is accepted.
- rst_in has priority over all other activity in the same cycle.

Optional Feature:
SW_LED_DIM_EN
- Defined:
  - A 2-bit free-running PWM counter is added; it is cleared on reset.
  - The final led output is the mode result ANDed with (pwm==0), giving 25% duty dimming.
  - The extra gating is registered, so led latency grows by 1 cycle.
  - sw_stable and sw_rise are unaffected.
- Undefined: no PWM logic; led is driven at full brightness with the latency above.

Test Plan:
All scenarios use N_CH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BLINK_DIV=8.
- Reset then sw=8'h00, mode=00 for 20 cycles -> led=0, sw_stable=0, sw_rise=0 throughout.
- Clean step: sw[0] 0->1 before edge 0, held; mode=00 -> sw_stable[0]=1 at edge 5, sw_rise[0] high for exactly the cycle after edge 5, led[0]=1 at edge 6.
- Bounce: sw[3] high 3 cycles, low 1 cycle, high 3 cycles, then low -> sw_stable[3] never changes and sw_rise[3] never pulses.
- Toggle mode: mode=01; sw[5] pressed and released cleanly twice -> led[5] reads 1 after the first press and 0 after the second; sw_stable[5] returns to 0 after each release.
- Blink: mode=10, sw=8'hFF stable -> led alternates 8'hFF/8'h00 every 8 cycles; mode=11 -> led=0 one cycle after mode is sampled.
- Reset mid-debounce: sw[7]=1 held; assert rst_in for 1 cycle at the third debounce count -> sw_stable[7] rises 5 edges after rst_in deasserts, not earlier. With SW_LED_DIM_EN defined, led is high 1 cycle in every 4.
